// File: rtl/frame_stream_pkg.sv
// Shared constants and encodings for the frame streamer: FSM states, sent-byte kinds, marker/escape bytes.
// The checksum state exists only when FRAME_STREAM_CRC_EN is defined.
package frame_stream_pkg;

  localparam logic [7:0] ESC_BYTE     = 8'hFD;
  localparam logic [7:0] DEF_SOF_BYTE = 8'hFE;
  localparam logic [7:0] DEF_EOF_BYTE = 8'hFF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_BYTE = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;
  localparam logic [2:0] ST_EOF  = 3'd6;
  localparam logic [2:0] ST_CRC  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SOF  = ST_SOF,
    S_RD   = ST_RD,
    S_LOAD = ST_LOAD,
    S_BYTE = ST_BYTE,
    S_WAIT = ST_WAIT,
`ifdef FRAME_STREAM_CRC_EN
    S_CRC  = ST_CRC,
`endif
    S_EOF  = ST_EOF
  } state_e;

  // What the byte currently in flight was, so WAIT knows where to go next.
  typedef enum logic [1:0] {K_SOF, K_DATA, K_CRC, K_EOF} kind_e;

  function automatic int bytes_per_pixel(input int pixel_w);
    return (pixel_w + 7) / 8;
  endfunction

endpackage

// File: rtl/frame_stream_tx_if.sv
// Frame streamer bus: request/select, frame RAM read port and uart_tx byte handshake.
// master = streamer side, slave = surrounding capture logic.
interface frame_stream_tx_if #(
  parameter int PIXEL_W = 3,
  parameter int SEL_W   = 1,
  parameter int ADDR_W  = 13
);
  logic               begin_frame;
  logic [SEL_W-1:0]   buf_sel;
  logic [PIXEL_W-1:0] pixel_data;
  logic [ADDR_W-1:0]  addr_out;
  logic [7:0]         tx_byte;
  logic               tx_start;
  logic               tx_done;
  logic               busy;

  modport master (
    input  begin_frame, buf_sel, pixel_data, tx_done,
    output addr_out, tx_byte, tx_start, busy
  );

  modport slave (
    output begin_frame, buf_sel, pixel_data, tx_done,
    input  addr_out, tx_byte, tx_start, busy
  );
endinterface

// File: rtl/stream_byte_escaper.sv
// Combinational: replaces a byte that collides with either frame marker by the escape byte.
module stream_byte_escaper
  import frame_stream_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = DEF_SOF_BYTE,
  parameter logic [7:0] EOF_BYTE = DEF_EOF_BYTE
) (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  assign data_o = (data_i == SOF_BYTE || data_i == EOF_BYTE) ? ESC_BYTE : data_i;
endmodule

// File: rtl/frame_stream_tx.sv
// Streams one frame buffer to uart_tx as SOF, escaped MSB-first pixel bytes, EOF; one byte in flight, paced by tx_done.
// Define FRAME_STREAM_CRC_EN to insert an escaped mod-256 checksum byte between the last data byte and EOF.
module frame_stream_tx
  import frame_stream_pkg::*;
#(
  parameter int         PIXEL_W  = 3,
  parameter int         NUM_PIX  = 3072,
  parameter int         NUM_BUFS = 2,
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] SOF_BYTE = DEF_SOF_BYTE,
  parameter logic [7:0] EOF_BYTE = DEF_EOF_BYTE
) (
  input logic               clk,
  input logic               rst,
  frame_stream_tx_if.master bus
);
  localparam int BYTES_PP = bytes_per_pixel(PIXEL_W);
  localparam int SHIFT_W  = 8 * BYTES_PP;
  localparam int SEL_W    = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int ADDR_W   = (NUM_BUFS * NUM_PIX > 1) ? $clog2(NUM_BUFS * NUM_PIX) : 1;
  localparam int PIX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int BC_W     = (BYTES_PP > 1) ? $clog2(BYTES_PP) : 1;

  state_e              state_q;
  kind_e               kind_q;
  logic [SEL_W-1:0]    sel_q;
  logic [PIX_W-1:0]    pix_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          tx_byte_q;
  logic                tx_start_q;
  logic                busy_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [BC_W-1:0]     bcnt_q;
  logic [1:0]          lat_q;
  logic [7:0]          esc_data_d;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [SEL_W-1:0] s, input logic [PIX_W-1:0] p);
    return ADDR_W'(s) * ADDR_W'(NUM_PIX) + ADDR_W'(p);
  endfunction

  // The byte to send is always the top of the shift register; it shifts left per byte.
  stream_byte_escaper #(.SOF_BYTE(SOF_BYTE), .EOF_BYTE(EOF_BYTE)) u_esc_data (
    .data_i (shift_q[SHIFT_W-1 -: 8]),
    .data_o (esc_data_d)
  );

`ifdef FRAME_STREAM_CRC_EN
  logic [7:0] sum_q;
  logic [7:0] esc_sum_d;

  stream_byte_escaper #(.SOF_BYTE(SOF_BYTE), .EOF_BYTE(EOF_BYTE)) u_esc_sum (
    .data_i (sum_q),
    .data_o (esc_sum_d)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= K_SOF;
      sel_q      <= '0;
      pix_q      <= '0;
      addr_q     <= '0;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      bcnt_q     <= '0;
      lat_q      <= 2'd0;
`ifdef FRAME_STREAM_CRC_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef FRAME_STREAM_CRC_EN
          sum_q <= 8'h00;
`endif
          if (bus.begin_frame) begin
            sel_q   <= bus.buf_sel;
            pix_q   <= '0;
            addr_q  <= addr_of(bus.buf_sel, '0);
            busy_q  <= 1'b1;
            state_q <= S_SOF;
          end
        end
        S_SOF: begin
          tx_byte_q  <= SOF_BYTE;
          tx_start_q <= 1'b1;
          kind_q     <= K_SOF;
          state_q    <= S_WAIT;
        end
        S_RD: begin
          if (lat_q == 2'(RD_LAT - 1)) begin
            lat_q   <= 2'd0;
            state_q <= S_LOAD;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        S_LOAD: begin
          shift_q <= SHIFT_W'(bus.pixel_data);
          bcnt_q  <= '0;
          state_q <= S_BYTE;
        end
        S_BYTE: begin
          tx_byte_q  <= esc_data_d;
          tx_start_q <= 1'b1;
          kind_q     <= K_DATA;
`ifdef FRAME_STREAM_CRC_EN
          sum_q      <= sum_q + esc_data_d;
`endif
          state_q    <= S_WAIT;
        end
`ifdef FRAME_STREAM_CRC_EN
        S_CRC: begin
          tx_byte_q  <= esc_sum_d;
          tx_start_q <= 1'b1;
          kind_q     <= K_CRC;
          state_q    <= S_WAIT;
        end
`endif
        S_EOF: begin
          tx_byte_q  <= EOF_BYTE;
          tx_start_q <= 1'b1;
          kind_q     <= K_EOF;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A done coinciding with our own start pulse cannot belong to this byte.
          if (bus.tx_done && !tx_start_q) begin
            case (kind_q)
              K_SOF: state_q <= S_RD;
              K_DATA: begin
                if (bcnt_q != BC_W'(BYTES_PP - 1)) begin
                  bcnt_q  <= bcnt_q + BC_W'(1);
                  shift_q <= shift_q << 8;
                  state_q <= S_BYTE;
                end else if (pix_q != PIX_W'(NUM_PIX - 1)) begin
                  pix_q   <= pix_q + PIX_W'(1);
                  addr_q  <= addr_of(sel_q, pix_q + PIX_W'(1));
                  state_q <= S_RD;
                end else begin
`ifdef FRAME_STREAM_CRC_EN
                  state_q <= S_CRC;
`else
                  state_q <= S_EOF;
`endif
                end
              end
`ifdef FRAME_STREAM_CRC_EN
              K_CRC: state_q <= S_EOF;
`endif
              default: begin
                busy_q  <= 1'b0;
                pix_q   <= '0;
                addr_q  <= addr_of(sel_q, '0);
                state_q <= S_IDLE;
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Drives four differently parameterised streamers from one directed-then-random sequence and
// checks every transmitted byte, address and handshake against a byte-list model of the frame format.
module tb_frame_stream_tx;
  localparam int NCFG = 4;

  function automatic int cfg_pw(input int k);
    case (k) 0: return 3; 1: return 12; 2: return 3; default: return 8; endcase
  endfunction
  function automatic int cfg_np(input int k);
    case (k) 0: return 4; 1: return 2; 2: return 2; default: return 3; endcase
  endfunction
  function automatic int cfg_nb(input int k);
    case (k) 3: return 4; default: return 2; endcase
  endfunction
  function automatic int cfg_rl(input int k);
    case (k) 1: return 2; 2: return 3; default: return 1; endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        bf_r  [NCFG];
  logic [3:0]  sel_r [NCFG];
  logic [15:0] mem   [NCFG][16];
  wire  [7:0]  txb_w  [NCFG];
  wire         txs_w  [NCFG];
  wire         txd_w  [NCFG];
  wire         busy_w [NCFG];
  wire  [15:0] addr_w [NCFG];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  for (genvar k = 0; k < NCFG; k++) begin : g
    localparam int PW = cfg_pw(k);
    localparam int NP = cfg_np(k);
    localparam int NB = cfg_nb(k);
    localparam int RL = cfg_rl(k);
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(NB * NP);

    frame_stream_tx_if #(.PIXEL_W(PW), .SEL_W(SW), .ADDR_W(AW)) bus ();

    frame_stream_tx #(
      .PIXEL_W(PW), .NUM_PIX(NP), .NUM_BUFS(NB), .RD_LAT(RL),
      .SOF_BYTE(8'hFE), .EOF_BYTE(8'hFF)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );

    // Frame RAM with an RL-deep output pipeline.
    logic [PW-1:0] pipe [RL];
    always @(posedge clk) begin
      pipe[0] <= mem[k][int'(bus.addr_out)][PW-1:0];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    // uart_tx stand-in: done pulse 10 cycles after each start.
    int unsigned dcnt = 0;
    always @(posedge clk) begin
      if (bus.tx_start) dcnt <= 10;
      else if (dcnt != 0) dcnt <= dcnt - 1;
    end

    assign bus.pixel_data  = pipe[RL-1];
    assign bus.tx_done     = (dcnt == 1);
    assign bus.begin_frame = bf_r[k];
    assign bus.buf_sel     = sel_r[k][SW-1:0];
    assign txb_w[k]  = bus.tx_byte;
    assign txs_w[k]  = bus.tx_start;
    assign txd_w[k]  = bus.tx_done;
    assign busy_w[k] = bus.busy;
    assign addr_w[k] = 16'(bus.addr_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] esc(input logic [7:0] b);
    return (b == 8'hFE || b == 8'hFF) ? 8'hFD : b;
  endfunction

  // Expected wire bytes: markers, zero-extended pixels MSB byte first, escaping, optional checksum.
  task automatic build_exp(input int k, input int sel);
    int pw = cfg_pw(k);
    int np = cfg_np(k);
    int bpp = (pw + 7) / 8;
    int sum = 0;
    int unsigned v;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hFE);
    for (int p = 0; p < np; p++) begin
      v = int'(mem[k][sel*np + p]) % (1 << pw);
      for (int j = bpp - 1; j >= 0; j--) begin
        b = esc(8'(v >> (8*j)));
        sum += int'(b);
        exp_q.push_back(b);
      end
    end
`ifdef FRAME_STREAM_CRC_EN
    exp_q.push_back(esc(8'(sum % 256)));
`endif
    exp_q.push_back(8'hFF);
  endtask

  task automatic run_frame(input int k, input int sel, input bit hold, input int rst_at);
    int np = cfg_np(k);
    int bpp = (cfg_pw(k) + 7) / 8;
    int rl = cfg_rl(k);
    int nb = 0, cyc = 0, chg = 0, p;
    bit outst = 1'b0, done = 1'b0;
    logic [15:0] last_addr;
    logic [7:0] last_byte;
    build_exp(k, sel);
    @(negedge clk);
    sel_r[k] = 4'(sel);
    bf_r[k] = 1'b1;
    last_addr = addr_w[k];
    last_byte = txb_w[k];
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!hold) bf_r[k] = 1'b0;
      sel_r[k] = 4'($urandom_range(0, 15));
      chk("busy_in_frame", busy_w[k], 1);
      if (addr_w[k] !== last_addr) begin
        last_addr = addr_w[k];
        chg = cyc;
        chk("addr_range", 32'(addr_w[k] >= sel*np && addr_w[k] < sel*np + np), 1);
      end
      if (txs_w[k]) begin
        chk("start_while_waiting", outst, 0);
        outst = 1'b1;
        if (nb >= exp_q.size()) chk("extra_byte", nb, exp_q.size());
        else begin
          chk($sformatf("cfg%0d_byte%0d", k, nb), txb_w[k], exp_q[nb]);
          if (nb == 0) chk("addr_at_sof", addr_w[k], sel*np);
          if (nb >= 1 && nb <= np*bpp && (nb - 1) % bpp == 0) begin
            p = (nb - 1) / bpp;
            chk("addr_pixel", addr_w[k], sel*np + p);
            if (p > 0) chk("rd_latency", cyc - chg, rl + 2);
          end
        end
        last_byte = txb_w[k];
        nb++;
        if (nb == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_addr", addr_w[k], 0);
          chk("rst_tx_byte", txb_w[k], 0);
          chk("rst_tx_start", txs_w[k], 0);
          chk("rst_busy", busy_w[k], 0);
          rst = 1'b0;
          bf_r[k] = 1'b0;
          repeat (20) begin
            @(negedge clk);
            chk("post_rst_no_start", txs_w[k], 0);
            chk("post_rst_busy", busy_w[k], 0);
          end
          return;
        end
        if (nb == exp_q.size()) bf_r[k] = 1'b0;
      end else begin
        chk("tx_byte_stable", txb_w[k], last_byte);
      end
      if (txd_w[k]) begin
        outst = 1'b0;
        if (nb == exp_q.size()) begin
          @(negedge clk);
          chk("busy_fall_on_eof_done", busy_w[k], 0);
          done = 1'b1;
        end
      end
    end
    chk("frame_completed", done, 1);
    chk("byte_count", nb, exp_q.size());
    repeat (12) begin
      @(negedge clk);
      chk("idle_no_start", txs_w[k], 0);
      chk("idle_busy", busy_w[k], 0);
    end
  endtask

  initial begin
    int k, sel, b;
    for (int i = 0; i < NCFG; i++) begin
      bf_r[i] = 1'b0;
      sel_r[i] = 4'd0;
      for (int a = 0; a < 16; a++) mem[i][a] = 16'h0000;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      chk("reset_addr", addr_w[i], 0);
      chk("reset_tx_byte", txb_w[i], 0);
      chk("reset_tx_start", txs_w[i], 0);
      chk("reset_busy", busy_w[i], 0);
    end
    rst = 1'b0;

    mem[0][0] = 16'd5; mem[0][1] = 16'd2; mem[0][2] = 16'd7; mem[0][3] = 16'd0;
    run_frame(0, 0, 1'b0, -1);
    for (int a = 4; a < 8; a++) mem[0][a] = 16'd1;
    run_frame(0, 1, 1'b0, -1);
    mem[1][0] = 16'h0FFE; mem[1][1] = 16'h00FF;
    run_frame(1, 0, 1'b0, -1);
    mem[2][0] = 16'd3; mem[2][1] = 16'd4;
    run_frame(2, 0, 1'b0, -1);
    run_frame(0, 1, 1'b1, 3);
    run_frame(0, 0, 1'b0, -1);
    mem[3][0] = 16'd10; mem[3][1] = 16'd20; mem[3][2] = 16'd30;
    run_frame(3, 0, 1'b0, -1);

    repeat (16) begin
      k = $urandom_range(0, NCFG - 1);
      sel = $urandom_range(0, cfg_nb(k) - 1);
      for (int a = 0; a < 16; a++) begin
        b = $urandom_range(0, 5);
        mem[k][a] = (b == 0) ? 16'hFFFE : (b == 1) ? 16'h00FF : 16'($urandom);
      end
      run_frame(k, sel, 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
- Parametrised frame-buffer streamer, successor to the fixed 3-bit/3072-pixel sender.
- Reads NUM_PIX pixels of PIXEL_W bits from one of NUM_BUFS buffers in a shared frame RAM and packs each pixel MSB-first into BYTES_PP bytes.
- Drives the existing uart_tx byte interface, wrapping each frame in start/end markers.
- Sits between the frame RAM read port and uart_tx in the capture top level.

Parameters:
- PIXEL_W, 3: pixel width in bits, 1..16.
- NUM_PIX, 3072: pixels per buffer.
- NUM_BUFS, 2: number of buffers; buffer b occupies addresses b*NUM_PIX .. b*NUM_PIX+NUM_PIX-1.
- RD_LAT, 1: frame RAM read latency in cycles, 1..3.
- SOF_BYTE, 8'hFE: start-of-frame marker.
- EOF_BYTE, 8'hFF: end-of-frame marker.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- begin_frame, in, 1: request a frame; sampled in IDLE only.
- buf_sel, in, SEL_W=max(1,clog2(NUM_BUFS)): buffer to send; latched on accepted begin_frame.
- pixel_data, in, PIXEL_W: RAM read data, valid RD_LAT cycles after addr_out changes.
- addr_out, out, ADDR_W=clog2(NUM_BUFS*NUM_PIX): RAM read address.
- tx_byte, out, 8: byte to uart_tx.
- tx_start, out, 1: one-cycle pulse that launches tx_byte (uart_tx i_Tx_DV).
- tx_done, in, 1: uart_tx o_Tx_Done, one-cycle pulse.
- busy, out, 1: high from the accepted begin_frame until EOF tx_done.

Behaviour:
- Reset values: state IDLE; addr_out 0; tx_byte 0; tx_start 0; busy 0; pixel index 0; latched select 0.
- BYTES_PP = ceil(PIXEL_W/8). Pixel zero-extended to 8*BYTES_PP bits and sent most significant byte first.
- Escaping: any data byte (or checksum byte) equal to SOF_BYTE or EOF_BYTE is replaced by 8'hFD. Markers are never escaped.
- addr_out = sel_q*NUM_PIX + pix_idx, computed at ADDR_W bits; it is a registered output.
- States and transitions:
  - IDLE: begin_frame=1 -> latch buf_sel, set busy, go to SOF.
  - SOF: tx_byte=SOF_BYTE, pulse tx_start -> WAIT.
  - RD: address already presented; count RD_LAT cycles -> LOAD.
  - LOAD: capture pixel_data into shift register, byte counter=0 -> BYTE.
  - BYTE: send escaped byte[counter], pulse tx_start -> WAIT.
  - WAIT: hold until tx_done, then choose the next state:
    - more bytes in the pixel -> BYTE;
    - last byte of a pixel that is not the last pixel -> increment pix_idx -> RD;
    - last byte of the last pixel -> CRC if enabled, else EOF;
    - after EOF -> clear busy and pix_idx -> IDLE.
  - EOF: tx_byte=EOF_BYTE, pulse tx_start -> WAIT.
- tx_start is never asserted while waiting for tx_done. tx_byte stays stable from tx_start until the next tx_start.
- begin_frame while busy is ignored, with no queuing. A buf_sel change mid-frame has no effect.
- tx_done outside WAIT is ignored.
- pix_idx wraps to 0 only at end of frame and never reaches NUM_PIX.
- rst mid-frame: immediate return to IDLE with all outputs at reset values. No EOF is sent.
- Frame length on the wire: 2 + NUM_PIX*BYTES_PP bytes, plus 1 with the checksum.

Optional Feature:
- FRAME_STREAM_CRC_EN defined: an 8-bit checksum byte is sent between the last data byte and EOF.
  - Checksum = sum mod 256 of all escaped data bytes as transmitted, then escaped itself.
  - The accumulator clears in IDLE.
- Undefined: no checksum state or accumulator logic; the EOF byte follows the last data byte directly.

Decomposition:
- Shared package frame_stream_pkg holds:
  - state encoding localparams;
  - the escape constant 8'hFD;
  - the default marker bytes.
- One natural sub-module: stream_byte_escaper.
  - Combinational: 8-bit in, 8-bit out, with SOF/EOF parameters.
  - Used for both data bytes and the checksum byte.
- uart_tx stays an external instance in the top level.

Test Plan:
- PIXEL_W=3, NUM_PIX=4, buf_sel=0, RAM[0..3]=5,2,7,0, tx_done returned 10 cycles after each tx_start -> bytes FE,05,02,07,00,FF; busy falls on the FF tx_done.
- Same setup, buf_sel=1, RAM[4..7]=1,1,1,1 -> addr_out visits 4..7 only; bytes FE,01,01,01,01,FF.
- PIXEL_W=12, NUM_PIX=2, RAM=12'hFFE,12'h0FF -> FE,0F,FD,00,FD,FF. Covers MSB-first packing and escaping of FE/FF data.
- RD_LAT=3, PIXEL_W=3, NUM_PIX=2, RAM=3,4 -> pixel_data is sampled exactly 3 cycles after each addr_out change; bytes FE,03,04,FF.
- begin_frame held high through an entire frame, with rst pulsed after the 2nd data byte:
  - output stops with no FF;
  - all outputs return to reset values;
  - the next begin_frame restarts at FE with addr_out 0.
- FRAME_STREAM_CRC_EN defined, PIXEL_W=8, NUM_PIX=3, RAM=10,20,30 -> FE,0A,14,1E,3C,FF.
